multicycle_alu: RTL and testbench



---
 rtl/multicycle_alu_pkg.sv | 32 +++
 rtl/multicycle_alu_core.sv | 37 +++
 rtl/multicycle_alu.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_alu.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_alu_pkg.sv
// Shared types for multicycle_alu: opcode mnemonics, FSM states and default widths.
// The MUL state exists only when MULTICYCLE_ALU_MUL_EN is defined.
package definitions;

  localparam int unsigned DEFAULT_W   = 8;
  localparam int unsigned DEFAULT_OPS = 4;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    XOR = 4'd4,
    NEG = 4'd5,
    GEQ = 4'd6,
    EQ  = 4'd7,
    NEQ = 4'd8,
    LSH = 4'd9,
    RSH = 4'd10,
    MUL = 4'd11,
    NOP = 4'd12
  } op_mne;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT
`ifdef MULTICYCLE_ALU_MUL_EN
    , ST_MUL
`endif
  } state_t;

endpackage

// File: rtl/multicycle_alu_core.sv
// Combinational single-cycle ALU slice: ADD..NEQ plus NOP (Out=0, Carry=0).
// Shift and MUL opcodes fall through to the NOP result here.
module alu_core
  import definitions::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  op_mne          op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   result,
  output logic           carry
);

  logic [W:0] sum;
  logic [W:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    result = '0;
    carry  = 1'b0;
    case (op)
      ADD: begin result = sum[W-1:0];  carry = sum[W];  end
      SUB: begin result = diff[W-1:0]; carry = diff[W]; end
      AND: result = a & b;
      OR:  result = a | b;
      XOR: result = a ^ b;
      NEG: result = ~a + {{(W-1){1'b0}}, 1'b1};
      GEQ: result = {{(W-1){1'b0}}, (a >= b)};
      EQ:  result = {{(W-1){1'b0}}, (a == b)};
      NEQ: result = {{(W-1){1'b0}}, (a != b)};
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Clocked ALU with single-cycle ops, iterative shifts and an optional shift-add
// multiplier enabled by defining MULTICYCLE_ALU_MUL_EN.
module multicycle_alu
  import definitions::*;
#(
  parameter int unsigned W   = DEFAULT_W,
  parameter int unsigned Ops = DEFAULT_OPS
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [W-1:0]   InputA,
  input  logic [W-1:0]   InputB,
  input  logic [Ops-1:0] OP,
  output logic [W-1:0]   Out,
  output logic           Zero,
  output logic           Parity,
  output logic           Odd,
  output logic           Carry,
  output logic           Busy,
  output logic           Done
);

  localparam int unsigned KW = $clog2(W);

  op_mne           op_mnemonic;
  op_mne           op_sel;
  state_t          state, state_next;
  logic [KW-1:0]   k;
  logic            is_shift;
  logic            go_shift;
  logic [W-1:0]    core_res;
  logic            core_c;

  logic [W-1:0]    sh;
  logic            sh_left;
  logic [W-1:0]    sh_next;
  logic            sh_bit;
  logic [KW-1:0]   cnt;

  logic            load;
  logic [W-1:0]    load_val;
  logic            load_c;

  always_comb begin
    op_mnemonic = op_mne'(OP);
    // Any opcode above MUL (including wide-Ops extensions) decodes as NOP
    op_sel      = (OP > Ops'(MUL)) ? NOP : op_mnemonic;
    k           = InputB[KW-1:0];
    is_shift    = (op_sel == LSH) || (op_sel == RSH);
    go_shift    = is_shift && (k != '0);
    sh_next     = sh_left ? {sh[W-2:0], 1'b0} : {1'b0, sh[W-1:1]};
    sh_bit      = sh_left ? sh[W-1] : sh[0];
  end

  alu_core #(.W(W)) u_core (
    .op     (op_sel),
    .a      (InputA),
    .b      (InputB),
    .result (core_res),
    .carry  (core_c)
  );

`ifdef MULTICYCLE_ALU_MUL_EN
  logic            go_mul;
  logic [2*W-1:0]  acc;
  logic [2*W-1:0]  mcand;
  logic [W-1:0]    mplier;
  logic [2*W-1:0]  prod_next;

  always_comb begin
    go_mul    = (op_sel == MUL);
    prod_next = acc + (mplier[0] ? mcand : '0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (state == ST_IDLE) begin
      if (Start && go_mul) begin
        acc    <= '0;
        mcand  <= {{W{1'b0}}, InputA};
        mplier <= InputB;
      end
    end else if (state == ST_MUL) begin
      acc    <= prod_next;
      mcand  <= {mcand[2*W-2:0], 1'b0};
      mplier <= {1'b0, mplier[W-1:1]};
    end
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          if (go_shift) state_next = ST_SHIFT;
`ifdef MULTICYCLE_ALU_MUL_EN
          else if (go_mul) state_next = ST_MUL;
`endif
        end
      end
      ST_SHIFT: if (cnt == '0) state_next = ST_IDLE;
`ifdef MULTICYCLE_ALU_MUL_EN
      ST_MUL:   if (cnt == '0) state_next = ST_IDLE;
`endif
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy   = (state != ST_IDLE);
    Zero   = ~|Out;
    Parity = ^Out;
    Odd    = Out[0];
  end

  // Single result-load path shared by every completing operation
  always_comb begin
    load     = 1'b0;
    load_val = core_res;
    load_c   = core_c;
    case (state)
      ST_IDLE: begin
        if (Start && !go_shift
`ifdef MULTICYCLE_ALU_MUL_EN
            && !go_mul
`endif
           ) begin
          load = 1'b1;
          if (is_shift) begin
            load_val = InputA;
            load_c   = 1'b0;
          end
        end
      end
      ST_SHIFT: begin
        load_val = sh_next;
        load_c   = sh_bit;
        load     = (cnt == '0);
      end
`ifdef MULTICYCLE_ALU_MUL_EN
      ST_MUL: begin
        load_val = prod_next[W-1:0];
        load_c   = |prod_next[2*W-1:W];
        load     = (cnt == '0);
      end
`endif
      default: ;
    endcase
  end

  // cnt holds the remaining iterations minus one; the op completes when it reads 0
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sh      <= '0;
      sh_left <= 1'b0;
      cnt     <= '0;
      Out     <= '0;
      Carry   <= 1'b0;
      Done    <= 1'b0;
    end else begin
      Done <= load;
      if (load) begin
        Out   <= load_val;
        Carry <= load_c;
      end
      case (state)
        ST_IDLE: begin
          if (Start && go_shift) begin
            sh      <= InputA;
            sh_left <= (op_sel == LSH);
            cnt     <= k - KW'(1);
          end
`ifdef MULTICYCLE_ALU_MUL_EN
          else if (Start && go_mul) begin
            cnt <= KW'(W - 1);
          end
`endif
        end
        ST_SHIFT: begin
          sh  <= sh_next;
          cnt <= cnt - KW'(1);
        end
`ifdef MULTICYCLE_ALU_MUL_EN
        ST_MUL: cnt <= cnt - KW'(1);
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (W=8); MUL expectations follow MULTICYCLE_ALU_MUL_EN.
module tb_multicycle_alu;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] InputA;
  logic [7:0] InputB;
  logic [3:0] OP;
  logic [7:0] Out;
  logic       Zero, Parity, Odd, Carry, Busy, Done;

  int checks = 0;
  int errors = 0;

  multicycle_alu #(.W(8), .Ops(4)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .InputA (InputA),
    .InputB (InputB),
    .OP     (OP),
    .Out    (Out),
    .Zero   (Zero),
    .Parity (Parity),
    .Odd    (Odd),
    .Carry  (Carry),
    .Busy   (Busy),
    .Done   (Done)
  );

  always #5 Clk = ~Clk;

  // Reference: result, carry and Start-to-Done latency from the opcode rules
  function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] o, output logic c, output int lat);
    int k;
    logic [8:0]  s;
    logic [15:0] p;
    k = int'(b[2:0]);
    o = 8'h00; c = 1'b0; lat = 1;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; o = s[7:0]; c = s[8]; end
      4'd1: begin o = a - b; c = (a >= b); end
      4'd2: o = a & b;
      4'd3: o = a | b;
      4'd4: o = a ^ b;
      4'd5: o = 8'h00 - a;
      4'd6: o = (a >= b) ? 8'd1 : 8'd0;
      4'd7: o = (a == b) ? 8'd1 : 8'd0;
      4'd8: o = (a != b) ? 8'd1 : 8'd0;
      4'd9: begin o = a << k; c = (k == 0) ? 1'b0 : a[8 - k]; lat = 1 + k; end
      4'd10: begin o = a >> k; c = (k == 0) ? 1'b0 : a[k - 1]; lat = 1 + k; end
`ifdef MULTICYCLE_ALU_MUL_EN
      4'd11: begin p = 16'(a) * 16'(b); o = p[7:0]; c = (p[15:8] != 8'h00); lat = 9; end
`endif
      default: ;
    endcase
  endfunction

  // Issue one op at a negedge and return what appears when Done rises
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output int lat);
    OP = op; InputA = a; InputB = b; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    lat = 1;
    while (Done !== 1'b1 && lat < 40) begin
      @(negedge Clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; Start = 1'b0; OP = 4'd0; InputA = 8'h00; InputB = 8'h00;
    repeat (3) @(negedge Clk);
    checks++; if (Out !== 8'h00) begin errors++; $display("FAIL reset_out got=%h exp=00", Out); end
    checks++; if (Carry !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b exp=0", Carry); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", Done); end
    checks++; if ({Zero, Parity, Odd} !== 3'b100) begin errors++; $display("FAIL reset_flags got=%b exp=100", {Zero, Parity, Odd}); end
    Reset = 1'b0;
  endtask

  task automatic test_add;
    int lat;
    run_op(4'd0, 8'hF0, 8'h20, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got=%0d exp=1", lat); end
    checks++; if (Out !== 8'h10 || Carry !== 1'b1) begin errors++; $display("FAIL add_result got=%h/%b exp=10/1", Out, Carry); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL add_busy got=%b exp=0", Busy); end
    checks++; if (Zero !== 1'b0 || Parity !== 1'b1) begin errors++; $display("FAIL add_flags got=%b%b exp=01", Zero, Parity); end
  endtask

  task automatic test_back_to_back;
    OP = 4'd1; InputA = 8'h05; InputB = 8'h07; Start = 1'b1;
    @(negedge Clk);
    checks++; if (Out !== 8'hFE || Carry !== 1'b0 || Done !== 1'b1) begin errors++; $display("FAIL b2b_sub got=%h/%b/%b exp=fe/0/1", Out, Carry, Done); end
    OP = 4'd7; InputA = 8'h33; InputB = 8'h33;
    @(negedge Clk);
    Start = 1'b0;
    checks++; if (Out !== 8'h01 || Carry !== 1'b0 || Done !== 1'b1) begin errors++; $display("FAIL b2b_eq got=%h/%b/%b exp=01/0/1", Out, Carry, Done); end
    @(negedge Clk);
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop got=%b exp=0", Done); end
  endtask

  task automatic test_shift_busy;
    OP = 4'd9; InputA = 8'h81; InputB = 8'h03; Start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (c == 2) begin
        OP = 4'd0; InputA = 8'h01; InputB = 8'h01; Start = 1'b1;
      end
      checks++; if (Busy !== 1'b1 || Done !== 1'b0) begin errors++; $display("FAIL lsh_busy_t%0d got=%b%b exp=10", c, Busy, Done); end
    end
    @(negedge Clk);
    Start = 1'b0;
    checks++; if (Busy !== 1'b0 || Done !== 1'b1) begin errors++; $display("FAIL lsh_done got=%b%b exp=01", Busy, Done); end
    checks++; if (Out !== 8'h08 || Carry !== 1'b0) begin errors++; $display("FAIL lsh_result got=%h/%b exp=08/0", Out, Carry); end
    @(negedge Clk);
    checks++; if (Done !== 1'b0 || Out !== 8'h08) begin errors++; $display("FAIL lsh_ignored_start got=%b/%h exp=0/08", Done, Out); end
  endtask

  task automatic test_rsh_edges;
    int lat;
    run_op(4'd10, 8'h01, 8'h01, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rsh1_latency got=%0d exp=2", lat); end
    checks++; if (Out !== 8'h00 || Carry !== 1'b1 || Zero !== 1'b1) begin errors++; $display("FAIL rsh1_result got=%h/%b/%b exp=00/1/1", Out, Carry, Zero); end
    run_op(4'd10, 8'hA7, 8'h08, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL rsh0_latency got=%0d exp=1", lat); end
    checks++; if (Out !== 8'hA7 || Carry !== 1'b0) begin errors++; $display("FAIL rsh0_result got=%h/%b exp=a7/0", Out, Carry); end
  endtask

  task automatic test_mul;
    int lat, elat;
    logic [7:0] eo;
    logic ec;
    model(4'd11, 8'h10, 8'h11, eo, ec, elat);
    run_op(4'd11, 8'h10, 8'h11, lat);
    checks++; if (lat !== elat) begin errors++; $display("FAIL mul_latency got=%0d exp=%0d", lat, elat); end
    checks++; if (Out !== eo || Carry !== ec) begin errors++; $display("FAIL mul_result got=%h/%b exp=%h/%b", Out, Carry, eo, ec); end
  endtask

  task automatic test_reset_abort;
    int lat;
    run_op(4'd0, 8'h21, 8'h03, lat);
    OP = 4'd11; InputA = 8'h10; InputB = 8'h11; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
`ifdef MULTICYCLE_ALU_MUL_EN
    checks++; if (Busy !== 1'b1 || Done !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b%b exp=10", Busy, Done); end
`endif
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    checks++; if (Busy !== 1'b0 || Done !== 1'b0 || Out !== 8'h00 || Carry !== 1'b0) begin errors++; $display("FAIL abort_state got=%b%b/%h/%b exp=00/00/0", Busy, Done, Out, Carry); end
    repeat (10) @(negedge Clk);
    checks++; if (Done !== 1'b0 || Out !== 8'h00) begin errors++; $display("FAIL abort_no_done got=%b/%h exp=0/00", Done, Out); end
    run_op(4'd0, 8'h01, 8'h01, lat);
    checks++; if (Out !== 8'h02 || lat !== 1) begin errors++; $display("FAIL abort_add got=%h/%0d exp=02/1", Out, lat); end
    OP = 4'd0; InputA = 8'h40; InputB = 8'h40; Start = 1'b1; Reset = 1'b1;
    @(negedge Clk);
    Start = 1'b0; Reset = 1'b0;
    checks++; if (Out !== 8'h00 || Done !== 1'b0) begin errors++; $display("FAIL reset_beats_start got=%h/%b exp=00/0", Out, Done); end
  endtask

  task automatic test_random;
    int lat, elat;
    logic [7:0] a, b, eo;
    logic [3:0] op;
    logic ec;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom);
      b  = 8'($urandom);
      model(op, a, b, eo, ec, elat);
      run_op(op, a, b, lat);
      checks++;
      if (lat !== elat || Out !== eo || Carry !== ec) begin
        errors++;
        $display("FAIL rand_op%0d a=%h b=%h got=%h/%b/lat%0d exp=%h/%b/lat%0d", op, a, b, Out, Carry, lat, eo, ec, elat);
      end
      checks++;
      if (Zero !== (eo == 8'h00) || Parity !== ^eo || Odd !== eo[0] || Busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_flags op%0d got=%b%b%b%b exp=%b%b%b0", op, Zero, Parity, Odd, Busy, (eo == 8'h00), ^eo, eo[0]);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; OP = 4'd0; InputA = 8'h00; InputB = 8'h00;
    test_reset;
    test_add;
    test_back_to_back;
    test_shift_busy;
    test_rsh_edges;
    test_mul;
    test_reset_abort;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
